// File: rtl/uart_pkg.sv
// Purpose: shared types, constants and parameter checks for the framed UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   rx_state_t     receiver FSM state encoding
//   PAR_*          parity mode selectors for the PARITY parameter
//   rx_params_ok   constant function used to reject illegal parameter sets at elaboration
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int WORD_SIZE_MIN    = 5;
  localparam int WORD_SIZE_MAX    = 9;
  localparam int CLKS_PER_BIT_MIN = 4;

  function automatic bit rx_params_ok(int word_size, int clks_per_bit, int parity,
                                      int stop_bits);
    return (word_size >= WORD_SIZE_MIN) && (word_size <= WORD_SIZE_MAX) &&
           (clks_per_bit >= CLKS_PER_BIT_MIN) &&
           (parity == PAR_NONE || parity == PAR_EVEN || parity == PAR_ODD) &&
           (stop_bits == 1 || stop_bits == 2);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: two-flop synchroniser for the serial line plus a falling-edge detector.
// Latency: rx_s lags rx by 2 clk; fall is combinational on rx_s and its previous value.
// Backpressure: none; free-running.
//   clk, rstn  clock and async active-low reset (all flops reset to line-idle 1)
//   rx         raw asynchronous serial input
//   rx_s       synchronised line value
//   fall       high for the one cycle where rx_s goes 1 -> 0
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Requires a genuine 1 -> 0 transition, so a line stuck low never re-triggers.
  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_framed.sv
// Purpose: UART receiver with 3-sample majority voting, optional parity and 1/2 stop bits.
// Latency: word presented (data_valid=1) the cycle after the final stop-bit decision.
// Backpressure: one-word holding register; a frame completing while it is full is dropped and
//   overrun pulses for one cycle.
//   clk, rstn              clock and async active-low reset
//   rx                     asynchronous serial line, idle high, LSB first
//   data_out/parity_err/frame_err  held word and its error flags, valid with data_valid
//   data_valid/data_ready  valid/ready handshake towards the consumer
//   overrun                one-cycle pulse when a completed frame is dropped
//   busy                   receiver FSM is not idle
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  if (!rx_params_ok(WORD_SIZE, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_param_check
    $error("uart_rx_framed: illegal parameters WORD_SIZE=%0d CLKS_PER_BIT=%0d PARITY=%0d STOP_BITS=%0d",
           WORD_SIZE, CLKS_PER_BIT, PARITY, STOP_BITS);
  end

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_SIZE);

  localparam logic [CW-1:0] IDX_S0   = CW'(H - 1);
  localparam logic [CW-1:0] IDX_S1   = CW'(H);
  localparam logic [CW-1:0] IDX_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] IDX_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_SIZE - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic                 rx_s;
  logic                 fall;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CW-1:0]        cnt;
  logic                 samp0;
  logic                 samp1;
  logic [WORD_SIZE-1:0] data_sr;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 par_flag;
  logic                 frm_flag;

  logic at_dec;
  logic at_last;
  logic bit_maj;
  logic complete;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign at_dec  = (cnt == IDX_DEC);
  assign at_last = (cnt == IDX_LAST);
  // Third vote is the live sample taken in the decision cycle itself.
  assign bit_maj = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign complete = (state == ST_STOP) && at_dec && (stop_idx == STOP_LAST);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fall) state_nxt = ST_START;
      end
      ST_START: begin
        // A start bit that votes high was a glitch; abandon at once.
        if (at_dec && bit_maj) state_nxt = ST_IDLE;
        else if (at_last)      state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (at_last && (bit_idx == BIT_LAST))
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (at_last) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        // Leave mid stop bit so the next start edge is caught as early as possible.
        if (complete) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      data_sr  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else begin
      if ((state == ST_IDLE) || (state_nxt == ST_IDLE)) begin
        cnt <= '0;
      end else if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (cnt == IDX_S0) samp0 <= rx_s;
      if (cnt == IDX_S1) samp1 <= rx_s;

      case (state)
        ST_IDLE: begin
          if (fall) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
          end
        end
        ST_DATA: begin
          if (at_dec)  data_sr <= {bit_maj, data_sr[WORD_SIZE-1:1]};
          if (at_last) bit_idx <= bit_idx + 1'b1;
        end
        ST_PARITY: begin
          // Total ones over data+parity must be even (even mode) or odd (odd mode).
          if (at_dec) par_flag <= ((^data_sr) ^ bit_maj) != (PARITY == PAR_ODD);
        end
        ST_STOP: begin
          if (at_dec && !bit_maj) frm_flag <= 1'b1;
          if (at_last)            stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete && (!data_valid || data_ready)) begin
        data_out   <= data_sr;
        parity_err <= (PARITY != PAR_NONE) && par_flag;
        // The final stop bit is decided this cycle, so fold its vote in directly.
        frame_err  <= frm_flag | ~bit_maj;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      overrun <= complete && data_valid && !data_ready;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Purpose: randomized scoreboard bench for uart_rx_framed (8N1, 8E1, 8O1, and a 16x glitch case).
// Latency: n/a.
// Backpressure: data_ready driven directed or randomly; overrun counted against a model.
`timescale 1ns/1ps
module tb_uart_rx_framed;
  import uart_pkg::*;

  localparam int CPB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic rx_n, rx_p, rx_g;
  logic rdy_n, rdy_p, rdy_g;
  logic [7:0] dout_n, dout_e, dout_o, dout_g;
  logic dv_n, dv_e, dv_o, dv_g;
  logic pe_n, pe_e, pe_o, pe_g;
  logic fe_n, fe_e, fe_o, fe_g;
  logic ov_n, ov_e, ov_o, ov_g;
  logic busy_n, busy_e, busy_o, busy_g;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ov_cnt_n = 0;
  bit   busyg_seen = 0;
  bit   dvg_seen = 0;
  bit   rand_rdy = 0;
  exp_t q_n[$];
  exp_t q_e[$];
  exp_t q_o[$];

  always #5 clk = ~clk;

  uart_rx_framed #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1)) u_n (
    .clk(clk), .rstn(rstn), .rx(rx_n), .data_out(dout_n), .data_valid(dv_n), .data_ready(rdy_n),
    .parity_err(pe_n), .frame_err(fe_n), .overrun(ov_n), .busy(busy_n));
  uart_rx_framed #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_e (
    .clk(clk), .rstn(rstn), .rx(rx_p), .data_out(dout_e), .data_valid(dv_e), .data_ready(rdy_p),
    .parity_err(pe_e), .frame_err(fe_e), .overrun(ov_e), .busy(busy_e));
  uart_rx_framed #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(1)) u_o (
    .clk(clk), .rstn(rstn), .rx(rx_p), .data_out(dout_o), .data_valid(dv_o), .data_ready(rdy_p),
    .parity_err(pe_o), .frame_err(fe_o), .overrun(ov_o), .busy(busy_o));
  uart_rx_framed #(.WORD_SIZE(8), .CLKS_PER_BIT(16), .PARITY(PAR_NONE), .STOP_BITS(1)) u_g (
    .clk(clk), .rstn(rstn), .rx(rx_g), .data_out(dout_g), .data_valid(dv_g), .data_ready(rdy_g),
    .parity_err(pe_g), .frame_err(fe_g), .overrun(ov_g), .busy(busy_g));

  // Parity error as defined by mode: even wants an even total of ones, odd wants an odd total.
  function automatic logic exp_perr(input int mode, input logic [7:0] d, input logic pb);
    int ones;
    ones = $countones(d) + int'(pb);
    if (mode == 1) return logic'((ones % 2) == 1);
    return logic'((ones % 2) == 0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int line, input logic v, input int n);
    if (line == 0) rx_n = v;
    else           rx_p = v;
    cyc(n);
  endtask

  // The stop level is held one extra clock: with the vote window at H-1..H+1 the next start
  // edge would otherwise coincide with the stop decision cycle and be missed.
  task automatic send_frame(input int line, input logic [7:0] d, input logic pb,
                            input logic sv, input bit push);
    exp_t e;
    if (push) begin
      e.d  = d;
      e.fe = ~sv;
      if (line == 0) begin
        e.pe = 1'b0;
        q_n.push_back(e);
      end else begin
        e.pe = exp_perr(1, d, pb);
        q_e.push_back(e);
        e.pe = exp_perr(2, d, pb);
        q_o.push_back(e);
      end
    end
    drive(line, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(line, d[i], CPB);
    if (line != 0) drive(line, pb, CPB);
    drive(line, sv, CPB + 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_n.size() + q_e.size() + q_o.size()) != 0 && t < 600) begin
      cyc(1);
      t++;
    end
    check("drain_pending", 32'(q_n.size() + q_e.size() + q_o.size()), 32'd0);
    cyc(4);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (dv_n && rdy_n) begin
        if (q_n.size() == 0) check("n_unexpected_word", 32'(dout_n), 32'hFFFF_FFFF);
        else begin
          e = q_n.pop_front();
          check("n_data", 32'(dout_n), 32'(e.d));
          check("n_parity_err", 32'(pe_n), 32'(e.pe));
          check("n_frame_err", 32'(fe_n), 32'(e.fe));
        end
      end
      if (dv_e && rdy_p) begin
        if (q_e.size() == 0) check("e_unexpected_word", 32'(dout_e), 32'hFFFF_FFFF);
        else begin
          e = q_e.pop_front();
          check("e_data", 32'(dout_e), 32'(e.d));
          check("e_parity_err", 32'(pe_e), 32'(e.pe));
          check("e_frame_err", 32'(fe_e), 32'(e.fe));
        end
      end
      if (dv_o && rdy_p) begin
        if (q_o.size() == 0) check("o_unexpected_word", 32'(dout_o), 32'hFFFF_FFFF);
        else begin
          e = q_o.pop_front();
          check("o_data", 32'(dout_o), 32'(e.d));
          check("o_parity_err", 32'(pe_o), 32'(e.pe));
          check("o_frame_err", 32'(fe_o), 32'(e.fe));
        end
      end
      if (ov_n)   ov_cnt_n++;
      if (busy_g) busyg_seen = 1;
      if (dv_g)   dvg_seen = 1;
    end
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) rdy_n = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       sv;
    logic       pb;
    int         gap;

    rstn = 1'b0;
    rx_n = 1'b1; rx_p = 1'b1; rx_g = 1'b1;
    rdy_n = 1'b1; rdy_p = 1'b1; rdy_g = 1'b1;
    fork
      monitor();
      rdy_driver();
    join_none

    #3;
    check("rst_data_out", 32'(dout_n), 32'd0);
    check("rst_data_valid", 32'(dv_n), 32'd0);
    check("rst_busy", 32'(busy_n), 32'd0);
    check("rst_overrun", 32'(ov_n), 32'd0);
    check("rst_errs", 32'({pe_n, fe_n}), 32'd0);
    cyc(3);
    rstn = 1'b1;
    cyc(4);

    // Basic 8N1 word.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    drain();

    // One-cycle glitch on an idle 16x line.
    rx_g = 1'b0;
    cyc(1);
    rx_g = 1'b1;
    cyc(60);
    check("glitch_busy_seen", 32'(busyg_seen), 32'd1);
    check("glitch_busy_end", 32'(busy_g), 32'd0);
    check("glitch_no_word", 32'(dvg_seen), 32'd0);

    // 0x03 with parity bit 1: even-mode error, odd-mode clean.
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    drain();

    // Low stop bit, line held low 3 more bit periods, then a good frame.
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 3 * CPB);
    drive(0, 1'b1, CPB);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back frames with the consumer stalled: second word dropped.
    rdy_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
    cyc(10);
    check("ovr_held_data", 32'(dout_n), 32'h11);
    check("ovr_held_valid", 32'(dv_n), 32'd1);
    check("ovr_pulses", 32'(ov_cnt_n), 32'd1);
    rdy_n = 1'b1;
    cyc(3);
    check("ovr_valid_falls", 32'(dv_n), 32'd0);
    check("ovr_queue_empty", 32'(q_n.size()), 32'd0);

    // Reset in the middle of the data bits of 0xFF.
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 3 * CPB);
    check("mid_frame_busy", 32'(busy_n), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_n), 32'd0);
    check("mid_rst_data_out", 32'(dout_n), 32'd0);
    check("mid_rst_valid", 32'(dv_n), 32'd0);
    check("mid_rst_errs", 32'({pe_n, fe_n, ov_n}), 32'd0);
    cyc(2);
    rx_n = 1'b1;
    rstn = 1'b1;
    cyc(CPB);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    drain();

    // Random traffic with random backpressure on the 8N1 receiver.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom);
      sv = ($urandom_range(0, 4) != 0);
      send_frame(0, d, 1'b0, sv, 1'b1);
      gap = sv ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
      drive(0, 1'b1, gap * CPB);
    end
    rand_rdy = 1'b0;
    cyc(2);
    rdy_n = 1'b1;
    drain();

    // Random words and parity bits on the even/odd pair.
    for (int i = 0; i < 12; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      send_frame(1, d, pb, 1'b1, 1'b1);
      drive(1, 1'b1, $urandom_range(0, 2) * CPB);
    end
    drain();

    check("final_overrun_total", 32'(ov_cnt_n), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
